raster_sample_averager: RTL and testbench

Upstream feeder for the raster RAM shim. Accumulates a power-of-two number of signed ADC samples per raster point, forms the arithmetic mean, sign-extends it to the RAM data width, and hands it over on the shim's `data`/`commit`/`finished` handshake. It runs one point per `start` pulse, is driven by the raster scan controller, and flags samples lost while a write is in flight.

---
 rtl/raster_sample_averager_pkg.sv | 20 ++
 rtl/raster_sample_averager.sv | 110 +++++++++++
 tb/tb_raster_sample_averager.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/raster_sample_averager_pkg.sv
// Shared raster definitions: state encoding, RAM word width and the
// accumulator-width derivation used by the sample averager.
package raster_sample_averager_pkg;

    localparam int unsigned RAM_DAT_WID = 24;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUMULATE,
        ST_COMMIT,
        ST_WAIT_FINISH_LOW
    } state_t;

    // Room for 2^(2^shift_wid - 1) full-scale samples without overflow.
    function automatic int unsigned acc_wid(input int unsigned adc_wid,
                                            input int unsigned shift_wid);
        return adc_wid + (32'd1 << shift_wid) - 1;
    endfunction

endpackage

// File: rtl/raster_sample_averager.sv
// Averages 2^shift signed ADC samples per raster point and hands the mean
// to the raster RAM shim over the data/commit/finished handshake.
module raster_sample_averager
    import raster_sample_averager_pkg::*;
#(
    parameter int unsigned ADC_WID   = 18,
    parameter int unsigned DAT_WID   = RAM_DAT_WID,
    parameter int unsigned SHIFT_WID = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [SHIFT_WID-1:0]        shift,
    input  logic signed [ADC_WID-1:0]   adc_data,
    input  logic                        adc_valid,
    output logic                        busy,
    output logic                        done,
    output logic                        overrun,
    output logic signed [DAT_WID-1:0]   data,
    output logic                        commit,
    input  logic                        finished
);

    localparam int unsigned ACC_WID = acc_wid(ADC_WID, SHIFT_WID);
    localparam int unsigned CNT_WID = (32'd1 << SHIFT_WID) - 1;

    state_t                     state;
    state_t                     state_next;
    logic [SHIFT_WID-1:0]       shift_q;
    logic signed [ACC_WID-1:0]  acc;
    logic signed [ACC_WID-1:0]  sum;
    logic signed [ADC_WID-1:0]  mean;
    logic [CNT_WID-1:0]         cnt;
    logic [CNT_WID-1:0]         last_cnt;
    logic                       last_sample;

    always_comb begin
        sum  = acc + ACC_WID'(adc_data);
        // Arithmetic shift floors toward -inf; the mean always fits ADC_WID.
        mean = ADC_WID'(sum >>> shift_q);
        last_cnt = '0;
        for (int unsigned i = 0; i < CNT_WID; i++) begin
            last_cnt[i] = (i < 32'(shift_q));
        end
        last_sample = adc_valid && (cnt == last_cnt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:            if (start)       state_next = ST_ACCUMULATE;
            ST_ACCUMULATE:      if (last_sample) state_next = ST_COMMIT;
            ST_COMMIT:          if (finished)    state_next = ST_WAIT_FINISH_LOW;
            ST_WAIT_FINISH_LOW: if (!finished)   state_next = ST_IDLE;
            default:                             state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy   = (state != ST_IDLE);
        commit = (state == ST_COMMIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= '0;
            acc     <= '0;
            cnt     <= '0;
            data    <= '0;
            overrun <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= (state == ST_WAIT_FINISH_LOW) && !finished;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        shift_q <= shift;
                        acc     <= '0;
                        cnt     <= '0;
                        overrun <= 1'b0;
                    end
                end
                ST_ACCUMULATE: begin
                    if (adc_valid) begin
                        acc <= sum;
                        cnt <= cnt + 1'b1;
                    end
                    if (last_sample) begin
                        data <= DAT_WID'(mean);
                    end
                end
                ST_COMMIT, ST_WAIT_FINISH_LOW: begin
                    if (adc_valid) begin
                        overrun <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_raster_sample_averager.sv
// Scoreboard bench for raster_sample_averager: expected means are queued when
// samples are driven and popped when commit is observed.
module tb_raster_sample_averager;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [2:0]         shift;
    logic signed [17:0] adc_data;
    logic               adc_valid;
    logic               busy;
    logic               done;
    logic               overrun;
    logic signed [23:0] data;
    logic               commit;
    logic               finished;

    int                 vectors = 0;
    int                 miscompares = 0;
    logic [23:0]        exp_q[$];
    int                 smp_q[$];

    raster_sample_averager #(
        .ADC_WID   (18),
        .DAT_WID   (24),
        .SHIFT_WID (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .shift     (shift),
        .adc_data  (adc_data),
        .adc_valid (adc_valid),
        .busy      (busy),
        .done      (done),
        .overrun   (overrun),
        .data      (data),
        .commit    (commit),
        .finished  (finished)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not reach summary (actual running, required finished)");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete point using smp_q as the sample list.
    task automatic run_point(input int s, input int fin_delay, input bit fin_early,
                             input bit inject, input int gap);
        longint      acc_m;
        logic [23:0] exp_v;
        logic [23:0] exp_d;
        int          n;
        n = smp_q.size();
        acc_m = 0;
        foreach (smp_q[i]) acc_m += longint'(smp_q[i]);
        exp_v = 24'(acc_m >>> s);
        exp_q.push_back(exp_v);

        shift = 3'(s);
        start = 1'b1;
        tick();
        start = 1'b0;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_after_start: got %b want 1", busy);
        end
        vectors++;
        if (overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL overrun_cleared_on_start: got %b want 0", overrun);
        end

        for (int i = 0; i < n; i++) begin
            adc_valid = 1'b1;
            adc_data  = 18'(smp_q[i]);
            if (fin_early && i == n - 1) finished = 1'b1;
            tick();
            adc_valid = 1'b0;
            if (i != n - 1) begin
                vectors++;
                if (commit !== 1'b0) begin
                    miscompares++;
                    $display("FAIL commit_early: sample %0d got %b want 0", i, commit);
                end
                repeat (gap) tick();
            end
        end

        vectors++;
        if (commit !== 1'b1) begin
            miscompares++;
            $display("FAIL commit_latency: got %b want 1", commit);
        end
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL scoreboard_empty: got 0 entries want 1");
            exp_d = 'x;
        end else begin
            exp_d = exp_q.pop_front();
        end
        vectors++;
        if (data !== exp_d) begin
            miscompares++;
            $display("FAIL data_value: got %h want %h", data, exp_d);
        end

        if (fin_early) begin
            tick();
            vectors++;
            if (commit !== 1'b0) begin
                miscompares++;
                $display("FAIL commit_one_cycle: got %b want 0", commit);
            end
            repeat (2) begin
                tick();
                vectors++;
                if (done !== 1'b0 || busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL wait_finish_low: done %b busy %b want 0 1", done, busy);
                end
            end
            finished = 1'b0;
        end else begin
            for (int d = 1; d < fin_delay; d++) begin
                if (inject && d == 1) begin
                    adc_valid = 1'b1;
                    adc_data  = 18'sd777;
                    start     = 1'b1;
                    shift     = 3'd5;
                end
                tick();
                adc_valid = 1'b0;
                start     = 1'b0;
                vectors++;
                if (commit !== 1'b1 || data !== exp_d) begin
                    miscompares++;
                    $display("FAIL commit_hold: commit %b data %h want 1 %h", commit, data, exp_d);
                end
            end
            finished = 1'b1;
            tick();
            vectors++;
            if (commit !== 1'b0 || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL commit_release: commit %b busy %b want 0 1", commit, busy);
            end
            finished = 1'b0;
        end

        tick();
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL done_pulse: done %b busy %b want 1 0", done, busy);
        end
        vectors++;
        if (overrun !== inject) begin
            miscompares++;
            $display("FAIL overrun_at_done: got %b want %b", overrun, inject);
        end
        tick();
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0 || data !== exp_d) begin
            miscompares++;
            $display("FAIL after_done: done %b busy %b data %h want 0 0 %h", done, busy, data, exp_d);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0; shift = '0; adc_data = '0; adc_valid = 1'b0; finished = 1'b0;
        tick();
        tick();
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || overrun !== 1'b0 || commit !== 1'b0 || data !== 24'h0) begin
            miscompares++;
            $display("FAIL reset_state: busy %b done %b overrun %b commit %b data %h want all 0",
                     busy, done, overrun, commit, data);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_idle_valid();
        adc_valid = 1'b1;
        adc_data  = 18'sd5;
        tick();
        tick();
        adc_valid = 1'b0;
        vectors++;
        if (overrun !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_valid_ignored: overrun %b busy %b want 0 0", overrun, busy);
        end
    endtask

    task automatic test_basic();
        smp_q = '{10, 20, 30, 41};
        run_point(2, 3, 1'b0, 1'b0, 1);
    endtask

    task automatic test_negative_floor();
        smp_q = '{-3, -4};
        run_point(1, 2, 1'b0, 1'b0, 0);
    endtask

    task automatic test_max_shift();
        smp_q = {};
        for (int i = 0; i < 128; i++) smp_q.push_back(-131072);
        run_point(7, 1, 1'b0, 1'b0, 0);
    endtask

    task automatic test_shift_zero();
        smp_q = '{131071};
        run_point(0, 1, 1'b0, 1'b0, 0);
    endtask

    task automatic test_overrun();
        smp_q = '{100, -50, 7, 8};
        run_point(2, 3, 1'b0, 1'b1, 0);
        smp_q = '{1, 2};
        run_point(1, 1, 1'b0, 1'b0, 0);
    endtask

    task automatic test_reset_mid_commit();
        smp_q = '{1000, 3000};
        shift = 3'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        foreach (smp_q[i]) begin
            adc_valid = 1'b1;
            adc_data  = 18'(smp_q[i]);
            tick();
        end
        adc_valid = 1'b0;
        vectors++;
        if (commit !== 1'b1 || data !== 24'd2000) begin
            miscompares++;
            $display("FAIL pre_reset_commit: commit %b data %h want 1 0007d0", commit, data);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if (commit !== 1'b0 || busy !== 1'b0 || data !== 24'h0) begin
            miscompares++;
            $display("FAIL reset_mid_commit: commit %b busy %b data %h want 0 0 0", commit, busy, data);
        end
        smp_q = '{-7, 9, 12, -1};
        run_point(2, 2, 1'b0, 1'b0, 0);
    endtask

    task automatic test_finished_early();
        smp_q = '{-100, 51};
        run_point(1, 1, 1'b1, 1'b0, 0);
    endtask

    task automatic test_back_to_back();
        for (int p = 0; p < 6; p++) begin
            int s;
            s = p % 4;
            smp_q = {};
            for (int i = 0; i < (1 << s); i++) begin
                smp_q.push_back(int'($urandom_range(262143, 0)) - 131072);
            end
            run_point(s, 1 + (p % 3), 1'b0, 1'b0, 0);
        end
    endtask

    initial begin
        test_reset();
        test_idle_valid();
        test_basic();
        test_negative_floor();
        test_max_shift();
        test_shift_zero();
        test_overrun();
        test_reset_mid_commit();
        test_finished_early();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
